// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper
// Contents: uart_rx_state_e (receiver FSM states), UART_DATA_BITS,
// clks_per_bit(freq, baud) for deriving the oversampling divisor.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte interface between uart_rx and its consumer
// Signals: io_data_valid (1-cycle byte strobe), io_data_packet (last good byte),
// framing_error / parity_error (1-cycle error strobes).
// Modports: master (uart_rx drives), slave (consumer, e.g. uart_decoder).
interface uart_rx_if;
    import uart_pkg::*;

    logic                      io_data_valid;
    logic [UART_DATA_BITS-1:0] io_data_packet;
    logic                      framing_error;
    logic                      parity_error;

    modport master (
        output io_data_valid,
        output io_data_packet,
        output framing_error,
        output parity_error
    );

    modport slave (
        input io_data_valid,
        input io_data_packet,
        input framing_error,
        input parity_error
    );

endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous 1-bit input
// Ports: clk, reset_n (async active-low), d (async input), q (synchronized).
// Parameter RESET_VAL: value both flops take in reset (idle level of the input).
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN)
// Ports: clk, reset_n (async active-low), rx (async serial line, idle high),
// io (uart_rx_if.master: io_data_valid, io_data_packet, framing_error, parity_error).
// Macro UART_RX_PARITY_EN: adds an even-parity bit after the data bits and
// makes parity_error live; without it parity_error is constant 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 40_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    uart_rx_if.master   io
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // Counter reload values: the counter runs down to 0 and the sample is
    // taken on the 0 cycle, so a load of N-1 spaces samples N cycles apart.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_divisor
        $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end

    logic rx_s;
    logic rx_prev;
    logic start_edge;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // Only a high-to-low transition starts a frame, so a line stuck low
    // (break, or the tail of a bad stop bit) cannot retrigger.
    assign start_edge = rx_prev & ~rx_s;

    uart_rx_state_e            state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      valid_q;
    logic [UART_DATA_BITS-1:0] packet_q;
    logic                      ferr_q;
    logic                      par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_q;

    // Even parity: data bits plus parity bit must XOR to 0.
    assign par_ok = ~(^{shift, par_bit});
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            valid_q  <= 1'b0;
            packet_q <= '0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (start_edge) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end

                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (rx_s) begin
                        // Line back high at mid start bit: noise, not a frame.
                        state <= IDLE;
                    end else begin
                        cnt   <= FULL_LOAD;
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        par_bit <= rx_s;
                        cnt     <= FULL_LOAD;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Leave at mid stop bit so a following start edge
                        // half a bit later is already being watched for.
                        state <= IDLE;
                        if (!rx_s) begin
                            ferr_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        if (!par_ok) begin
                            perr_q <= 1'b1;
                        end
`endif
                        if (rx_s && par_ok) begin
                            packet_q <= shift;
                            valid_q  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.io_data_valid  = valid_q;
    assign io.io_data_packet = packet_q;
    assign io.framing_error  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign io.parity_error   = perr_q;
`else
    assign io.parity_error   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LATENCY  = 3 + CPB / 2 + 10 * CPB;
`else
    localparam int LATENCY  = 3 + CPB / 2 + 9 * CPB;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;

    uart_rx_if io ();

    uart_rx #(
        .CLK_FREQ_HZ (CLK_FREQ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .io      (io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid    = 0;
    int         n_ferr     = 0;
    int         n_perr     = 0;
    int         total_perr = 0;
    int         n_overlap  = 0;
    int         n_wide     = 0;
    int         last_valid_cyc = 0;
    logic [7:0] pkts[$];
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;
    logic       prev_p = 1'b0;

    always @(negedge clk) begin
        if (io.io_data_valid) begin
            n_valid++;
            pkts.push_back(io.io_data_packet);
            last_valid_cyc = cyc;
        end
        if (io.framing_error) n_ferr++;
        if (io.parity_error) begin
            n_perr++;
            total_perr++;
        end
        if (io.io_data_valid && (io.framing_error || io.parity_error)) n_overlap++;
        if ((io.io_data_valid && prev_v) || (io.framing_error && prev_f) ||
            (io.parity_error && prev_p)) n_wide++;
        prev_v = io.io_data_valid;
        prev_f = io.framing_error;
        prev_p = io.parity_error;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_valid = 0;
        n_ferr  = 0;
        n_perr  = 0;
        pkts.delete();
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    // Drives one full frame starting now; rx is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic bad_par, output int drop_cyc);
        drop_cyc = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit((^data) ^ bad_par);
`endif
        hold_bit(stop);
    endtask

    task automatic test_reset();
        idle(5);
        checks++;
        if ({io.io_data_valid, io.framing_error, io.parity_error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000",
                     {io.io_data_valid, io.framing_error, io.parity_error});
        end
        checks++;
        if (io.io_data_packet !== 8'h00) begin
            errors++;
            $display("FAIL reset_packet: got %h expected 00", io.io_data_packet);
        end
        reset_n = 1'b1;
        clear_mon();
        idle(100);
        checks++;
        if (n_valid != 0 || n_ferr != 0 || n_perr != 0) begin
            errors++;
            $display("FAIL idle_pulses: got v=%0d f=%0d p=%0d expected 0 0 0",
                     n_valid, n_ferr, n_perr);
        end
        checks++;
        if (io.io_data_packet !== 8'h00) begin
            errors++;
            $display("FAIL idle_packet: got %h expected 00", io.io_data_packet);
        end
    endtask

    task automatic test_single_frame();
        int drop;
        clear_mon();
        send_frame(8'h93, 1'b1, 1'b0, drop);
        idle(40);
        checks++;
        if (n_valid != 1 || pkts.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d valid expected 1", n_valid);
        end else begin
            checks++;
            if (pkts[0] !== 8'h93) begin
                errors++;
                $display("FAIL single_data: got %h expected 93", pkts[0]);
            end
            checks++;
            if (last_valid_cyc - drop < LATENCY - 1 || last_valid_cyc - drop > LATENCY + 1) begin
                errors++;
                $display("FAIL single_latency: got %0d expected %0d+-1",
                         last_valid_cyc - drop, LATENCY);
            end
        end
        checks++;
        if (io.io_data_packet !== 8'h93) begin
            errors++;
            $display("FAIL single_hold: got %h expected 93", io.io_data_packet);
        end
    endtask

    task automatic test_back_to_back();
        int         drop;
        logic [7:0] exp_bytes[4];
        exp_bytes = '{8'h00, 8'h40, 8'h00, 8'h93};
        clear_mon();
        for (int i = 0; i < 4; i++) send_frame(exp_bytes[i], 1'b1, 1'b0, drop);
        idle(20);
        checks++;
        if (n_valid != 4 || pkts.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d valid expected 4", n_valid);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pkts[i] !== exp_bytes[i]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", i, pkts[i], exp_bytes[i]);
                end
            end
        end
        checks++;
        if (n_ferr != 0 || n_perr != 0) begin
            errors++;
            $display("FAIL b2b_errors: got f=%0d p=%0d expected 0 0", n_ferr, n_perr);
        end
    endtask

    task automatic test_glitch();
        int drop;
        clear_mon();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(200);
        checks++;
        if (n_valid != 0 || n_ferr != 0 || n_perr != 0) begin
            errors++;
            $display("FAIL glitch_pulses: got v=%0d f=%0d p=%0d expected 0 0 0",
                     n_valid, n_ferr, n_perr);
        end
        send_frame(8'h13, 1'b1, 1'b0, drop);
        idle(20);
        checks++;
        if (n_valid != 1 || io.io_data_packet !== 8'h13) begin
            errors++;
            $display("FAIL glitch_next: got %0d valid data %h expected 1 valid data 13",
                     n_valid, io.io_data_packet);
        end
    endtask

    task automatic test_framing_error();
        int drop;
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0, drop);
        idle(24);
        checks++;
        if (n_ferr != 1 || n_valid != 0) begin
            errors++;
            $display("FAIL framing_pulse: got f=%0d v=%0d expected f=1 v=0", n_ferr, n_valid);
        end
        checks++;
        if (io.io_data_packet !== 8'h13) begin
            errors++;
            $display("FAIL framing_packet: got %h expected 13", io.io_data_packet);
        end
        rx = 1'b1;
        idle(40);
        checks++;
        if (n_ferr != 1 || n_valid != 0) begin
            errors++;
            $display("FAIL framing_low_line: got f=%0d v=%0d expected f=1 v=0", n_ferr, n_valid);
        end
        send_frame(8'h01, 1'b1, 1'b0, drop);
        idle(20);
        checks++;
        if (n_valid != 1 || io.io_data_packet !== 8'h01) begin
            errors++;
            $display("FAIL framing_next: got %0d valid data %h expected 1 valid data 01",
                     n_valid, io.io_data_packet);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         drop;
        logic [7:0] d;
        d = 8'h5A;
        clear_mon();
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(d[i]);
        rx = d[4];
        idle(CPB / 2);
        reset_n = 1'b0;
        rx      = 1'b1;
        idle(3);
        checks++;
        if (io.io_data_packet !== 8'h00 || io.io_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b data %h expected v=0 data 00",
                     io.io_data_valid, io.io_data_packet);
        end
        reset_n = 1'b1;
        idle(200);
        checks++;
        if (n_valid != 0 || n_ferr != 0 || n_perr != 0) begin
            errors++;
            $display("FAIL midreset_aborted: got v=%0d f=%0d p=%0d expected 0 0 0",
                     n_valid, n_ferr, n_perr);
        end
        send_frame(8'h80, 1'b1, 1'b0, drop);
        idle(20);
        checks++;
        if (n_valid != 1 || io.io_data_packet !== 8'h80) begin
            errors++;
            $display("FAIL midreset_next: got %0d valid data %h expected 1 valid data 80",
                     n_valid, io.io_data_packet);
        end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        int drop;
        clear_mon();
        send_frame(8'h93, 1'b1, 1'b1, drop);
        idle(20);
        checks++;
        if (n_perr != 1 || n_valid != 0 || n_ferr != 0) begin
            errors++;
            $display("FAIL parity_bad: got p=%0d v=%0d f=%0d expected 1 0 0",
                     n_perr, n_valid, n_ferr);
        end
        checks++;
        if (io.io_data_packet !== 8'h80) begin
            errors++;
            $display("FAIL parity_bad_packet: got %h expected 80", io.io_data_packet);
        end
        clear_mon();
        send_frame(8'h93, 1'b1, 1'b0, drop);
        idle(20);
        checks++;
        if (n_perr != 0 || n_valid != 1 || io.io_data_packet !== 8'h93) begin
            errors++;
            $display("FAIL parity_good: got p=%0d v=%0d data %h expected 0 1 93",
                     n_perr, n_valid, io.io_data_packet);
        end
`else
        checks++;
        if (total_perr != 0) begin
            errors++;
            $display("FAIL parity_tied: got %0d parity pulses expected 0", total_perr);
        end
`endif
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (n_overlap != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_overlap);
        end
        checks++;
        if (n_wide != 0) begin
            errors++;
            $display("FAIL pulse_width: got %0d wide pulses expected 0", n_wide);
        end
    endtask

    initial begin
        idle(1);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_parity();
        test_pulse_shape();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
